// File: rtl/wb_memory_pkg.sv
// rtl/wb_memory_pkg.sv - shared types and constants for the banked Wishbone memory
package wb_memory_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    RESP
  } state_t;

  // At least one select bit, so a single-bank build can still flag out-of-range hits.
  function automatic int bsel_w(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/wb_mem_rdmux.sv
// rtl/wb_mem_rdmux.sv - combinational read-data select across SRAM banks
module wb_mem_rdmux
  import wb_memory_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BSEL_W    = 1
) (
  input  logic [DATA_W*NUM_BANKS-1:0] dout,
  input  logic [BSEL_W-1:0]           bank,
  output logic [DATA_W-1:0]           rdata
);

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank == BSEL_W'(k)) rdata = dout[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/wb_memory_banked.sv
// rtl/wb_memory_banked.sv - Wishbone slave in front of NUM_BANKS single-port SRAM macros
module wb_memory_banked
  import wb_memory_pkg::*;
#(
  parameter int NUM_BANKS    = 2,
  parameter int BANK_ADDR_W  = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                             io_wbs_clk,
  input  logic                             io_wbs_rst,
  input  logic [31:0]                      io_wbs_adr,
  input  logic [31:0]                      io_wbs_datwr,
  input  logic [3:0]                       io_wbs_sel,
  input  logic                             io_wbs_we,
  input  logic                             io_wbs_stb,
  input  logic                             io_wbs_cyc,
  output logic [31:0]                      io_wbs_datrd,
  output logic                             io_wbs_ack,
  output logic                             io_wbs_err,
  output logic [NUM_BANKS-1:0]             csb_n,
  output logic [NUM_BANKS-1:0]             web_n,
  output logic [MASK_W*NUM_BANKS-1:0]      wmask,
  output logic [BANK_ADDR_W*NUM_BANKS-1:0] addr,
  output logic [DATA_W*NUM_BANKS-1:0]      din,
  input  logic [DATA_W*NUM_BANKS-1:0]      dout
);

  localparam int              BSEL_W     = bsel_w(NUM_BANKS);
  localparam int              ADR_HI     = 2 + BANK_ADDR_W + BSEL_W;
  localparam logic [BSEL_W:0] BANK_LIMIT = (BSEL_W+1)'(NUM_BANKS);
  localparam logic [1:0]      LAT_LAST   = 2'(READ_LATENCY);

  state_t                 state;
  logic [BSEL_W-1:0]      req_bank;
  logic [BSEL_W-1:0]      bank_q;
  logic [BANK_ADDR_W-1:0] req_offset;
  logic [BANK_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]      din_q;
  logic [DATA_W-1:0]      rd_data;
  logic [MASK_W-1:0]      wmask_q;
  logic [NUM_BANKS-1:0]   req_onehot;
  logic [1:0]             lat_cnt;
  logic                   req_valid;
  logic                   req_oob;
  logic                   unused_adr;

  assign req_bank   = io_wbs_adr[2+BANK_ADDR_W +: BSEL_W];
  assign req_offset = io_wbs_adr[2 +: BANK_ADDR_W];
  assign req_oob    = {1'b0, req_bank} >= BANK_LIMIT;
  assign req_valid  = (state == IDLE) && io_wbs_cyc && io_wbs_stb && !io_wbs_ack && !io_wbs_err;
  assign unused_adr = ^{io_wbs_adr[31:ADR_HI], io_wbs_adr[1:0]};

  always_comb begin
    req_onehot = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      req_onehot[k] = (req_bank == BSEL_W'(k));
    end
  end

  // Address, data and mask are broadcast; only the chip select picks the bank.
  assign wmask = {NUM_BANKS{wmask_q}};
  assign addr  = {NUM_BANKS{addr_q}};
  assign din   = {NUM_BANKS{din_q}};

  wb_mem_rdmux #(
    .NUM_BANKS(NUM_BANKS),
    .BSEL_W   (BSEL_W)
  ) u_rdmux (
    .dout (dout),
    .bank (bank_q),
    .rdata(rd_data)
  );

  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      state        <= IDLE;
      csb_n        <= '1;
      web_n        <= '1;
      wmask_q      <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      bank_q       <= '0;
      lat_cnt      <= '0;
      io_wbs_datrd <= '0;
      io_wbs_ack   <= 1'b0;
      io_wbs_err   <= 1'b0;
    end else begin
      // Strobes and handshakes are one-cycle pulses unless re-asserted below.
      csb_n      <= '1;
      web_n      <= '1;
      io_wbs_ack <= 1'b0;
      io_wbs_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            bank_q  <= req_bank;
            addr_q  <= req_offset;
            din_q   <= io_wbs_datwr;
            wmask_q <= io_wbs_sel;
            lat_cnt <= '0;
            if (req_oob) begin
              io_wbs_err <= 1'b1;
              state      <= RESP;
            end else if (io_wbs_we) begin
              io_wbs_ack <= 1'b1;
              state      <= WRITE;
              if (|io_wbs_sel) begin
                csb_n <= ~req_onehot;
                web_n <= ~req_onehot;
              end
            end else begin
              csb_n <= ~req_onehot;
              state <= READ_WAIT;
            end
          end
        end
        WRITE: state <= IDLE;
        READ_WAIT: begin
          if (!io_wbs_cyc) begin
            state <= IDLE;
          end else if (lat_cnt == LAT_LAST) begin
            io_wbs_datrd <= rd_data;
            io_wbs_ack   <= 1'b1;
            state        <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_memory_banked.sv
// tb/tb_wb_memory_banked.sv - directed and randomized Wishbone traffic against two memory configurations
module tb_wb_memory_banked;

  logic        io_wbs_clk = 1'b0;
  logic        io_wbs_rst = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] datwr = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        tgt = 1'b0;

  always #5 io_wbs_clk = ~io_wbs_clk;

  // Configuration A: 2 banks, latency 1.  Configuration B: 3 banks, latency 2.
  logic [31:0] datrd_a, datrd_b;
  logic        ack_a, ack_b, err_a, err_b;
  logic [1:0]  csb_n_a, web_n_a;
  logic [7:0]  wmask_a;
  logic [17:0] addr_a;
  logic [63:0] din_a, dout_a;
  logic [2:0]  csb_n_b, web_n_b;
  logic [11:0] wmask_b;
  logic [26:0] addr_b;
  logic [95:0] din_b, dout_b;

  wb_memory_banked #(.NUM_BANKS(2), .BANK_ADDR_W(9), .READ_LATENCY(1)) dut_a (
    .io_wbs_clk(io_wbs_clk), .io_wbs_rst(io_wbs_rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_sel(sel), .io_wbs_we(we), .io_wbs_stb(stb & ~tgt), .io_wbs_cyc(cyc & ~tgt),
    .io_wbs_datrd(datrd_a), .io_wbs_ack(ack_a), .io_wbs_err(err_a),
    .csb_n(csb_n_a), .web_n(web_n_a), .wmask(wmask_a), .addr(addr_a), .din(din_a), .dout(dout_a));

  wb_memory_banked #(.NUM_BANKS(3), .BANK_ADDR_W(9), .READ_LATENCY(2)) dut_b (
    .io_wbs_clk(io_wbs_clk), .io_wbs_rst(io_wbs_rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_sel(sel), .io_wbs_we(we), .io_wbs_stb(stb & tgt), .io_wbs_cyc(cyc & tgt),
    .io_wbs_datrd(datrd_b), .io_wbs_ack(ack_b), .io_wbs_err(err_b),
    .csb_n(csb_n_b), .web_n(web_n_b), .wmask(wmask_b), .addr(addr_b), .din(din_b), .dout(dout_b));

  logic [31:0] datrd_v;
  logic        ack_v, err_v;
  logic [2:0]  csb_v, web_v;
  logic [11:0] wmask_v;
  logic [26:0] addr_v;
  logic [95:0] din_v;
  assign datrd_v = tgt ? datrd_b : datrd_a;
  assign ack_v   = tgt ? ack_b : ack_a;
  assign err_v   = tgt ? err_b : err_a;
  assign csb_v   = tgt ? csb_n_b : {1'b1, csb_n_a};
  assign web_v   = tgt ? web_n_b : {1'b1, web_n_a};
  assign wmask_v = tgt ? wmask_b : {4'h0, wmask_a};
  assign addr_v  = tgt ? addr_b : {9'h0, addr_a};
  assign din_v   = tgt ? din_b : {32'h0, din_a};

  // Behavioural SRAM macros: write on a low-strobe edge, read data valid LAT edges after capture.
  for (genvar k = 0; k < 2; k++) begin : g_sram_a
    logic [31:0] mem [512];
    logic [31:0] q1;
    always @(posedge io_wbs_clk) begin
      if (!csb_n_a[k]) begin
        if (!web_n_a[k]) begin
          for (int b = 0; b < 4; b++)
            if (wmask_a[k*4+b]) mem[addr_a[k*9 +: 9]][b*8 +: 8] <= din_a[k*32+b*8 +: 8];
        end else begin
          q1 <= mem[addr_a[k*9 +: 9]];
        end
      end
    end
    assign dout_a[k*32 +: 32] = q1;
  end

  for (genvar k = 0; k < 3; k++) begin : g_sram_b
    logic [31:0] mem [512];
    logic [31:0] q1, q2;
    always @(posedge io_wbs_clk) begin
      if (!csb_n_b[k]) begin
        if (!web_n_b[k]) begin
          for (int b = 0; b < 4; b++)
            if (wmask_b[k*4+b]) mem[addr_b[k*9 +: 9]][b*8 +: 8] <= din_b[k*32+b*8 +: 8];
        end else begin
          q1 <= mem[addr_b[k*9 +: 9]];
        end
      end
      q2 <= q1;
    end
    assign dout_b[k*32 +: 32] = q2;
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [31:0] ref_mem [int];
  logic [2:0]  snap_csb, snap_web;
  logic [11:0] snap_wmask;
  logic [26:0] snap_addr;
  logic [95:0] snap_din;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_wbs_clk);
    #1;
  endtask

  function automatic int key_of(input logic t, input logic [31:0] a);
    return int'(t) * 65536 + int'((a >> 2) & (t ? 32'd2047 : 32'd1023));
  endfunction

  function automatic bit in_range(input logic t, input logic [31:0] a);
    return !t || (((a >> 11) & 32'd3) != 32'd3);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mk_adr(input int w);
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFF_F000) | (32'(w) << 2) | (r & 32'd3);
  endfunction

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_v && !err_v && n < 20);
  endtask

  // One transaction with stb held through the response cycle, then released.
  task automatic xfer(input logic t, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int n, output bit got_ack, output bit got_err,
                      output int strobes, output int wstrobes);
    tgt = t; adr = a; datwr = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    n = 0; got_ack = 0; got_err = 0; strobes = 0; wstrobes = 0;
    while (!got_ack && !got_err && n < 20) begin
      tick();
      n++;
      if (csb_v != 3'b111) strobes++;
      if (web_v != 3'b111) wstrobes++;
      if (n == 1) begin
        snap_csb = csb_v; snap_web = web_v; snap_wmask = wmask_v; snap_addr = addr_v; snap_din = din_v;
      end
      got_ack = ack_v;
      got_err = err_v;
    end
    tick();
    chk("ack_one_cycle", ack_v, 0);
    chk("err_one_cycle", err_v, 0);
    chk("no_restart", csb_v, 3'b111);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic do_write(input logic t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n, st, ws, k;
    bit ga, ge;
    xfer(t, 1'b1, a, d, s, n, ga, ge, st, ws);
    k = key_of(t, a);
    if (in_range(t, a)) begin
      chk("wr_ack", ga, 1);
      chk("wr_err", ge, 0);
      chk("wr_lat", n, 1);
      chk("wr_strobe", st, s != 0);
      chk("wr_web", ws, s != 0);
      ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : 32'hx, d, s);
    end else begin
      chk("err_flag", ge, 1);
      chk("err_noack", ga, 0);
      chk("err_lat", n, 1);
      chk("err_nostrobe", st, 0);
    end
    chk("wr_datrd_hold", datrd_v, t ? last_b : last_a);
  endtask

  task automatic do_read(input logic t, input logic [31:0] a);
    int n, st, ws, k;
    bit ga, ge;
    xfer(t, 1'b0, a, 32'h0, 4'h0, n, ga, ge, st, ws);
    k = key_of(t, a);
    if (in_range(t, a)) begin
      chk("rd_ack", ga, 1);
      chk("rd_err", ge, 0);
      chk("rd_lat", n, t ? 4 : 3);
      chk("rd_strobe", st, 1);
      chk("rd_web", ws, 0);
      chk("rd_data", datrd_v, ref_mem[k]);
      if (t) last_b = ref_mem[k]; else last_a = ref_mem[k];
    end else begin
      chk("err_flag", ge, 1);
      chk("err_noack", ga, 0);
      chk("err_lat", n, 1);
      chk("err_nostrobe", st, 0);
      chk("rd_datrd_hold", datrd_v, t ? last_b : last_a);
    end
  endtask

  initial begin
    int w, n, n_ack, n_err;
    logic [31:0] a;
    int words_a[$];

    #1 io_wbs_rst = 1'b1;
    #1;
    chk("rst_ack_a", ack_a, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_datrd_a", datrd_a, 0);
    chk("rst_csb_a", csb_n_a, 2'b11);
    chk("rst_web_a", web_n_a, 2'b11);
    chk("rst_wmask_a", wmask_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_din_a", din_a, 0);
    chk("rst_csb_b", csb_n_b, 3'b111);
    chk("rst_datrd_b", datrd_b, 0);
    chk("rst_ack_b", ack_b, 0);
    tick();
    tick();
    io_wbs_rst = 1'b0;
    tick();

    do_write(0, 32'h14, 32'hDEADBEEF, 4'hF);
    chk("w1_csb", snap_csb, 3'b110);
    chk("w1_web", snap_web, 3'b110);
    chk("w1_wmask", snap_wmask[3:0], 4'hF);
    chk("w1_addr", snap_addr[8:0], 9'h005);
    chk("w1_din", snap_din[31:0], 32'hDEADBEEF);
    do_read(0, 32'h14);
    chk("r1_data", datrd_v, 32'hDEADBEEF);

    do_write(0, 32'h814, 32'h11223344, 4'hF);
    do_write(0, 32'h814, 32'hAABBCCDD, 4'h2);
    chk("w2_csb", snap_csb, 3'b101);
    chk("w2_wmask", snap_wmask[7:4], 4'h2);
    chk("w2_addr", snap_addr[17:9], 9'h005);
    chk("w2_din", snap_din[63:32], 32'hAABBCCDD);
    do_read(0, 32'h814);
    chk("r2_data", datrd_v, 32'h1122CC44);

    do_write(0, 32'h14, 32'h0, 4'h0);
    do_read(0, 32'h14);
    chk("r3_nosel_data", datrd_v, 32'hDEADBEEF);

    tgt = 0; adr = 32'h814; we = 0; cyc = 1; stb = 1;
    tick();
    cyc = 0; stb = 0;
    n_ack = 0; n_err = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_v) n_ack++;
      if (err_v) n_err++;
    end
    chk("abort_noack", n_ack, 0);
    chk("abort_noerr", n_err, 0);
    chk("abort_csb", csb_v, 3'b111);
    chk("abort_datrd", datrd_v, last_a);
    do_read(0, 32'h814);

    adr = 32'h14; cyc = 1; stb = 1;
    tick();
    chk("mid_rst_pre_csb", csb_v, 3'b110);
    io_wbs_rst = 1'b1;
    #1;
    chk("mid_rst_csb", csb_v, 3'b111);
    chk("mid_rst_ack", ack_v, 0);
    chk("mid_rst_datrd", datrd_v, 0);
    last_a = '0;
    tick();
    cyc = 0; stb = 0;
    io_wbs_rst = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack_v || err_v) n_ack++;
    end
    chk("mid_rst_nohandshake", n_ack, 0);
    do_read(0, 32'h14);

    do_write(1, 32'h40, 32'hCAFEF00D, 4'hF);
    do_write(1, 32'h840, 32'h0BADC0DE, 4'hF);
    do_read(1, 32'h40);
    chk("b_r1_data", datrd_v, 32'hCAFEF00D);
    do_write(1, 32'h1800, 32'h12345678, 4'hF);
    do_read(1, 32'h1800);
    chk("b_err_datrd", datrd_v, 32'hCAFEF00D);

    tgt = 1; we = 0; adr = 32'h40; cyc = 1; stb = 1;
    wait_ack(n);
    chk("b2b_lat1", n, 4);
    chk("b2b_data1", datrd_v, 32'hCAFEF00D);
    adr = 32'h840;
    tick();
    chk("b2b_gap_ack", ack_v, 0);
    chk("b2b_gap_csb", csb_v, 3'b111);
    wait_ack(n);
    chk("b2b_lat2", n, 4);
    chk("b2b_data2", datrd_v, 32'h0BADC0DE);
    cyc = 0; stb = 0;
    tick();
    last_b = 32'h0BADC0DE;

    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(0, 1023);
      do_write(0, mk_adr(w), $urandom(), 4'hF);
      words_a.push_back(w);
    end
    for (int i = 0; i < 40; i++) begin
      w = words_a[$urandom_range(0, words_a.size() - 1)];
      a = mk_adr(w);
      if ($urandom_range(0, 1) == 1) do_read(0, a);
      else do_write(0, a, $urandom(), 4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 20; i++) begin
      a = mk_adr($urandom_range(0, 2047));
      do_write(1, a, $urandom(), 4'hF);
      do_read(1, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
